// File: rtl/guess_pkg.sv
// Shared ASCII constants and letter classification for the guess FIFO.
package guess_pkg;

    localparam logic [7:0] ASCII_A_UP = 8'h41;
    localparam logic [7:0] ASCII_Z_UP = 8'h5A;
    localparam logic [7:0] ASCII_A_LO = 8'h61;
    localparam logic [7:0] ASCII_Z_LO = 8'h7A;
    localparam int unsigned CASE_BIT  = 5;

    function automatic logic is_letter(input logic [7:0] b);
        return ((b >= ASCII_A_UP) && (b <= ASCII_Z_UP)) ||
               ((b >= ASCII_A_LO) && (b <= ASCII_Z_LO));
    endfunction

endpackage

// File: rtl/guess_fifo_rise_detect.sv
// Registered rising-edge detector; INIT sets the reset value of the history flop.
module rise_detect #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) level_q <= INIT;
        else     level_q <= level;
    end

    always_comb begin
        rise = level & ~level_q;
    end

endmodule

// File: rtl/guess_fifo.sv
// Receive-side guess FIFO between UART receiver and game FSM.
// Define GUESS_FIFO_FILTER_EN to accept letters only (folded to uppercase) and add the reject pulse.
module guess_fifo
    import guess_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    input  logic [DATA_W-1:0]          rx_byte,
    input  logic                       game_rdy,
    output logic [DATA_W-1:0]          guess,
    output logic                       guess_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
`ifdef GUESS_FIFO_FILTER_EN
    output logic                       reject,
`endif
    output logic                       overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_req;
    logic              accept;
    logic              push;
    logic              pop;
    logic              drop;
    logic [DATA_W-1:0] wr_data;

    // History flop resets high so a level held across reset release is not a push.
    rise_detect #(.INIT(1'b1)) u_rise (
        .clk   (clk),
        .rst   (rst),
        .level (ready),
        .rise  (push_req)
    );

    always_comb begin
        wr_data = rx_byte;
`ifdef GUESS_FIFO_FILTER_EN
        accept            = is_letter(rx_byte[7:0]);
        wr_data[CASE_BIT] = 1'b0;
`else
        accept = 1'b1;
`endif
        full  = (count == CNT_W'(DEPTH));
        empty = (count == '0);
        pop   = game_rdy & ~empty;
        push  = push_req & accept & (~full | pop);
        drop  = push_req & accept & full & ~pop;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            guess       <= '0;
            guess_valid <= 1'b0;
            overflow    <= 1'b0;
`ifdef GUESS_FIFO_FILTER_EN
            reject      <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                guess  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            guess_valid <= pop;
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            if (drop) overflow <= 1'b1;
`ifdef GUESS_FIFO_FILTER_EN
            reject <= push_req & ~accept;
`endif
        end
    end

endmodule
